rvsteel_gpio_input_filter: RTL and testbench

Per-pin input conditioning stage that sits between the GPIO pads and the `gpio_input` port of the GPIO controller. It synchronizes asynchronous pad inputs into the `clock` domain, debounces each pin with a per-pin counter, and produces a clean filtered vector for the GPIO controller. It also detects rising and falling edges on the filtered value and raises a level interrupt through a small memory-mapped register set on the same bus as the other peripherals.

---
 rtl/rvsteel_gpio_input_filter.sv | 183 ++++++++++++++++++
 tb/tb_rvsteel_gpio_input_filter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_gpio_input_filter.sv
// GPIO input conditioning: two-flop synchronizer, per-pin debounce counter,
// edge detection on the debounced level and a small register set that holds
// the edge enables and pending flags behind a level interrupt.
//
// Register index = rw_address[4:2]
//   0 FILTERED  RO   debounced levels
//   1 RAW       RO   synchronized, unfiltered levels
//   2 RISE_EN   RW   rising-edge interrupt enables
//   3 FALL_EN   RW   falling-edge interrupt enables
//   4 PENDING   R/W1C pending edge events
//   5-7         reads 0, writes ignored

module rvsteel_gpio_input_filter #(
    parameter int GPIO_WIDTH      = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4:0]            rw_address,
    output logic [31:0]           read_data,
    input  logic                  read_request,
    output logic                  read_response,
    input  logic [31:0]           write_data,
    input  logic [3:0]            write_strobe,
    input  logic                  write_request,
    output logic                  write_response,
    input  logic [GPIO_WIDTH-1:0] pad_input,
    output logic [GPIO_WIDTH-1:0] gpio_filtered,
    output logic                  irq
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    localparam logic [2:0] IDX_FILTERED = 3'd0;
    localparam logic [2:0] IDX_RAW      = 3'd1;
    localparam logic [2:0] IDX_RISE_EN  = 3'd2;
    localparam logic [2:0] IDX_FALL_EN  = 3'd3;
    localparam logic [2:0] IDX_PENDING  = 3'd4;

    logic [GPIO_WIDTH-1:0] r_sync1;
    logic [GPIO_WIDTH-1:0] r_sync2;
    logic [GPIO_WIDTH-1:0] r_filt;
    logic [CW-1:0]         r_cnt [GPIO_WIDTH];
    logic [GPIO_WIDTH-1:0] r_rise_en;
    logic [GPIO_WIDTH-1:0] r_fall_en;
    logic [GPIO_WIDTH-1:0] r_pend;
    logic [31:0]           r_read_data;
    logic                  r_read_response;
    logic                  r_write_response;

    logic [GPIO_WIDTH-1:0] w_filt_next;
    logic [CW-1:0]         w_cnt_next [GPIO_WIDTH];
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_fall;
    logic [GPIO_WIDTH-1:0] w_set;
    logic [GPIO_WIDTH-1:0] w_clr;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [2:0]            w_index;
    logic                  w_aligned;
    logic                  w_wr_ok;
    logic                  w_wr_rise_en;
    logic                  w_wr_fall_en;
    logic                  w_wr_pend;
    logic                  w_rd_ok;
    logic [31:0]           w_rd_mux;
    logic                  w_unused_wdata;

    assign w_index   = rw_address[4:2];
    assign w_aligned = (rw_address[1:0] == 2'b00);
    assign w_wdata   = write_data[GPIO_WIDTH-1:0];

    // Upper data bits are only meaningful for wider pin counts.
    assign w_unused_wdata = ^write_data;

    // Only full-word aligned writes change state; every write is still acknowledged.
    assign w_wr_ok      = write_request && w_aligned && (write_strobe == 4'hF);
    assign w_wr_rise_en = w_wr_ok && (w_index == IDX_RISE_EN);
    assign w_wr_fall_en = w_wr_ok && (w_index == IDX_FALL_EN);
    assign w_wr_pend    = w_wr_ok && (w_index == IDX_PENDING);
    assign w_rd_ok      = read_request && w_aligned;

    // Two-flop synchronizer for the asynchronous pad levels.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_input;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next-state: a differing level must persist DEBOUNCE_CYCLES samples.
    always_comb begin
        w_filt_next = r_filt;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (r_sync2[i] == r_filt[i]) begin
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_filt_next[i] = r_sync2[i];
                w_cnt_next[i]  = '0;
            end else begin
                w_cnt_next[i] = r_cnt[i] + CNT_ONE;
            end
        end
    end

    // Edges are taken from the next filtered value so pending sets on the same edge.
    assign w_rise = w_filt_next & ~r_filt;
    assign w_fall = ~w_filt_next & r_filt;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = w_wr_pend ? w_wdata : '0;

    // Debounced level and per-pin stability counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_filt <= '0;
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_filt <= w_filt_next;
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    // Enable registers and pending flags; a new event wins over a same-edge clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_pend    <= '0;
        end else begin
            if (w_wr_rise_en) begin
                r_rise_en <= w_wdata;
            end
            if (w_wr_fall_en) begin
                r_fall_en <= w_wdata;
            end
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    // Read mux; every field is zero-extended to the bus width.
    always_comb begin
        w_rd_mux = '0;
        case (w_index)
            IDX_FILTERED: w_rd_mux[GPIO_WIDTH-1:0] = r_filt;
            IDX_RAW:      w_rd_mux[GPIO_WIDTH-1:0] = r_sync2;
            IDX_RISE_EN:  w_rd_mux[GPIO_WIDTH-1:0] = r_rise_en;
            IDX_FALL_EN:  w_rd_mux[GPIO_WIDTH-1:0] = r_fall_en;
            IDX_PENDING:  w_rd_mux[GPIO_WIDTH-1:0] = r_pend;
            default:      w_rd_mux = '0;
        endcase
    end

    // Registered read data and one-cycle bus acknowledges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_read_data      <= '0;
            r_read_response  <= 1'b0;
            r_write_response <= 1'b0;
        end else begin
            if (w_rd_ok) begin
                r_read_data <= w_rd_mux;
            end
            r_read_response  <= read_request;
            r_write_response <= write_request;
        end
    end

    assign read_data      = r_read_data;
    assign read_response  = r_read_response;
    assign write_response = r_write_response;
    assign gpio_filtered  = r_filt;
    assign irq            = |r_pend;

endmodule

// File: tb/tb_rvsteel_gpio_input_filter.sv
// Directed bench for the GPIO input filter: reset behaviour, debounce timing,
// edge interrupts, set-versus-clear priority and bus acceptance rules.

module tb_rvsteel_gpio_input_filter;

    localparam int W = 2;
    localparam int D = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    rw_address = '0;
    logic [31:0]   read_data;
    logic          read_request = 1'b0;
    logic          read_response;
    logic [31:0]   write_data = '0;
    logic [3:0]    write_strobe = '0;
    logic          write_request = 1'b0;
    logic          write_response;
    logic [W-1:0]  pad_input = '0;
    logic [W-1:0]  gpio_filtered;
    logic          irq;

    int checks = 0;
    int errors = 0;

    rvsteel_gpio_input_filter #(
        .GPIO_WIDTH      (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rw_address     (rw_address),
        .read_data      (read_data),
        .read_request   (read_request),
        .read_response  (read_response),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .write_request  (write_request),
        .write_response (write_response),
        .pad_input      (pad_input),
        .gpio_filtered  (gpio_filtered),
        .irq            (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        rw_address    = addr;
        write_data    = data;
        write_strobe  = strb;
        write_request = 1'b1;
        @(negedge clock);
        check("write_response", {31'd0, write_response}, 32'd1);
        write_request = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        rw_address   = addr;
        read_request = 1'b1;
        @(negedge clock);
        check("read_response", {31'd0, read_response}, 32'd1);
        check(tag, read_data, exp);
        read_request = 1'b0;
    endtask

    initial begin
        // Reset held with toggling pads: everything stays at zero.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            pad_input = W'(i);
        end
        check("rst_filtered", {30'd0, gpio_filtered}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_read_response", {31'd0, read_response}, 32'd0);
        check("rst_write_response", {31'd0, write_response}, 32'd0);

        // Release with pin0 high: filtered after 2+D edges, no interrupt.
        pad_input = 2'b01;
        reset     = 1'b1;
        cycles(17);
        check("rel_filt_early", {30'd0, gpio_filtered}, 32'd0);
        cycles(1);
        check("rel_filt", {30'd0, gpio_filtered}, 32'd1);
        check("rel_irq", {31'd0, irq}, 32'd0);
        bus_read(5'h04, 32'd1, "raw_read");
        bus_read(5'h00, 32'd1, "filtered_read");

        // Return low, then a 15-cycle glitch must be rejected.
        pad_input = 2'b00;
        cycles(20);
        check("low_filt", {30'd0, gpio_filtered}, 32'd0);
        pad_input = 2'b01;
        cycles(15);
        pad_input = 2'b00;
        cycles(20);
        check("glitch_reject", {30'd0, gpio_filtered}, 32'd0);

        // Rising edge with RISE_EN: exact latency and interrupt on the same edge.
        bus_write(5'h08, 32'h1, 4'hF);
        pad_input = 2'b01;
        cycles(17);
        check("rise_filt_early", {30'd0, gpio_filtered}, 32'd0);
        check("rise_irq_early", {31'd0, irq}, 32'd0);
        cycles(1);
        check("rise_filt", {30'd0, gpio_filtered}, 32'd1);
        check("rise_irq", {31'd0, irq}, 32'd1);
        bus_read(5'h10, 32'h1, "pending_rise");
        bus_write(5'h10, 32'h1, 4'hF);
        check("clear_irq", {31'd0, irq}, 32'd0);
        bus_read(5'h10, 32'h0, "pending_cleared");

        // Falling pin0 without FALL_EN sets nothing.
        pad_input = 2'b00;
        cycles(20);
        check("fall0_filt", {30'd0, gpio_filtered}, 32'd0);
        check("fall0_irq", {31'd0, irq}, 32'd0);
        bus_read(5'h10, 32'h0, "fall0_pending");

        // Pin1 falls on the same edge a W1C of bit1 is accepted: set wins.
        bus_write(5'h0C, 32'h2, 4'hF);
        pad_input = 2'b10;
        cycles(20);
        check("pin1_high", {30'd0, gpio_filtered}, 32'd2);
        check("pin1_rise_no_irq", {31'd0, irq}, 32'd0);
        pad_input = 2'b00;
        cycles(17);
        check("pin1_before_fall", {30'd0, gpio_filtered}, 32'd2);
        bus_write(5'h10, 32'h2, 4'hF);
        check("pin1_fallen", {30'd0, gpio_filtered}, 32'd0);
        check("set_wins_irq", {31'd0, irq}, 32'd1);
        bus_read(5'h10, 32'h2, "set_wins_pending");
        bus_write(5'h10, 32'h2, 4'hF);
        check("clear1_irq", {31'd0, irq}, 32'd0);

        // Bus rules: partial strobe and misaligned writes are ignored.
        bus_write(5'h08, 32'h3, 4'h3);
        bus_read(5'h08, 32'h1, "partial_strobe_ignored");
        bus_write(5'h09, 32'h3, 4'hF);
        bus_read(5'h08, 32'h1, "misaligned_write_ignored");
        bus_read(5'h18, 32'h0, "index6_reads_zero");
        bus_read(5'h08, 32'h1, "rise_en_read");
        bus_read(5'h0D, 32'h1, "misaligned_read_holds");
        bus_read(5'h0C, 32'h2, "fall_en_read");

        // Back-to-back: write then read next cycle, then another read.
        rw_address    = 5'h08;
        write_data    = 32'h3;
        write_strobe  = 4'hF;
        write_request = 1'b1;
        @(negedge clock);
        check("b2b_wr_resp", {31'd0, write_response}, 32'd1);
        check("b2b_rd_resp_idle", {31'd0, read_response}, 32'd0);
        write_request = 1'b0;
        read_request  = 1'b1;
        @(negedge clock);
        check("b2b_rd_resp1", {31'd0, read_response}, 32'd1);
        check("b2b_rise_en", read_data, 32'h3);
        check("b2b_wr_resp_drop", {31'd0, write_response}, 32'd0);
        rw_address = 5'h0C;
        @(negedge clock);
        check("b2b_rd_resp2", {31'd0, read_response}, 32'd1);
        check("b2b_fall_en", read_data, 32'h2);
        read_request = 1'b0;
        @(negedge clock);
        check("b2b_rd_resp_drop", {31'd0, read_response}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
